// File: rtl/fetch_pred_pkg.sv
// Purpose: shared constants, width helpers and entry layout for the fetch PC predictor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: default reset PC, BTB index/tag width helpers, saturating
// direction-counter constants, and the BTB entry layout.
package fetch_pred_pkg;

    localparam logic [31:0] DEF_RESET_PC    = 32'h4000_0000;
    localparam int          DEF_XLEN        = 32;
    localparam int          DEF_BTB_ENTRIES = 16;
    localparam int          DEF_CNT_BITS    = 2;

    // Index bits select the entry from pc[idx_bits+1:2]; the two low PC bits
    // are always zero for aligned instructions and are not part of the tag.
    function automatic int idx_bits(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int tag_bits(input int xlen, input int entries);
        return xlen - idx_bits(entries) - 2;
    endfunction

    // Counter encodings: the MSB is the predicted direction.
    // weak-taken     = MSB 1, rest 0
    // weak-not-taken = MSB 0, rest 1
    function automatic int cnt_weak_taken(input int cnt_bits);
        return 1 << (cnt_bits - 1);
    endfunction

    function automatic int cnt_weak_not_taken(input int cnt_bits);
        return (1 << (cnt_bits - 1)) - 1;
    endfunction

    function automatic int cnt_sat_high(input int cnt_bits);
        return (1 << cnt_bits) - 1;
    endfunction

    function automatic int cnt_sat_low(input int cnt_bits);
        return (cnt_bits > 0) ? 0 : 0;
    endfunction

    localparam int DEF_TAG_W = tag_bits(DEF_XLEN, DEF_BTB_ENTRIES);

    // Entry layout for the default configuration. The BTB declares the same
    // layout locally with its own parameter-derived widths so that non-default
    // configurations keep the identical field order.
    typedef struct packed {
        logic                    valid;
        logic [DEF_TAG_W-1:0]    tag;
        logic [DEF_XLEN-1:0]     target;
        logic [DEF_CNT_BITS-1:0] cnt;
    } btb_entry_t;

endpackage

// File: rtl/branch_target_buffer.sv
// Purpose: direct-mapped BTB with per-entry saturating direction counters.
// Latency: lookup is combinational; updates take effect at the next clock edge.
// Backpressure: none; an update is accepted every cycle it is presented.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset (clears valid bits,
//                                 counters to weakly-not-taken)
//   lk_idx, lk_tag                lookup address split into index / tag
//   lk_hit, lk_taken, lk_target   lookup result: hit, predicted direction, stored target
//   up_en                         apply an update this cycle
//   up_idx, up_tag                update address split into index / tag
//   up_taken, up_jump, up_target  resolved direction, jump flag, resolved target
module branch_target_buffer
    import fetch_pred_pkg::*;
#(
    parameter int  XLEN     = DEF_XLEN,
    parameter int  ENTRIES  = DEF_BTB_ENTRIES,
    parameter int  CNT_BITS = DEF_CNT_BITS,
    localparam int IDX_W    = idx_bits(ENTRIES),
    localparam int TAG_W    = tag_bits(XLEN, ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] lk_idx,
    input  logic [TAG_W-1:0] lk_tag,
    output logic             lk_hit,
    output logic             lk_taken,
    output logic [XLEN-1:0]  lk_target,
    input  logic             up_en,
    input  logic [IDX_W-1:0] up_idx,
    input  logic [TAG_W-1:0] up_tag,
    input  logic             up_taken,
    input  logic             up_jump,
    input  logic [XLEN-1:0]  up_target
);

    localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(cnt_weak_taken(CNT_BITS));
    localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'(cnt_weak_not_taken(CNT_BITS));
    localparam logic [CNT_BITS-1:0] CNT_HI  = CNT_BITS'(cnt_sat_high(CNT_BITS));
    localparam logic [CNT_BITS-1:0] CNT_LO  = CNT_BITS'(cnt_sat_low(CNT_BITS));
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    typedef struct packed {
        logic                valid;
        logic [TAG_W-1:0]    tag;
        logic [XLEN-1:0]     target;
        logic [CNT_BITS-1:0] cnt;
    } entry_t;

    entry_t mem [ENTRIES];

    entry_t lk_ent;
    entry_t up_ent;
    logic   up_hit;

    // Lookup reads the array as it stands before this cycle's edge, so a
    // same-index update in the same cycle is not visible until next cycle.
    always_comb begin
        lk_ent    = mem[lk_idx];
        lk_hit    = lk_ent.valid && (lk_ent.tag == lk_tag);
        lk_taken  = lk_hit && lk_ent.cnt[CNT_BITS-1];
        lk_target = lk_ent.target;
    end

    always_comb begin
        up_ent = mem[up_idx];
        up_hit = up_ent.valid && (up_ent.tag == up_tag);
    end

    // Tags and targets are only meaningful behind a valid bit, so only the
    // valid bits and counters are reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i].valid <= 1'b0;
                mem[i].cnt   <= CNT_WNT;
            end
        end else if (up_en) begin
            if (up_hit) begin
                if (up_jump) begin
                    // Unconditional control flow: pin the entry to strongly taken.
                    mem[up_idx].cnt <= CNT_HI;
                end else if (up_taken) begin
                    if (up_ent.cnt != CNT_HI) begin
                        mem[up_idx].cnt <= up_ent.cnt + CNT_ONE;
                    end
                end else begin
                    if (up_ent.cnt != CNT_LO) begin
                        mem[up_idx].cnt <= up_ent.cnt - CNT_ONE;
                    end
                end
                if (up_taken) begin
                    mem[up_idx].target <= up_target;
                end
            end else if (up_taken) begin
                // Taken miss claims the slot, evicting whatever aliased there.
                mem[up_idx].valid  <= 1'b1;
                mem[up_idx].tag    <= up_tag;
                mem[up_idx].target <= up_target;
                mem[up_idx].cnt    <= up_jump ? CNT_HI : CNT_WT;
            end
        end
    end

endmodule

// File: rtl/fetch_pc_predictor.sv
// Purpose: fetch PC register with BTB-based next-PC prediction and X-stage redirect.
// Latency: pc_f follows next_pc one cycle later; flush/next_pc are combinational.
// Backpressure: stall holds pc_f; a mispredict redirect overrides stall.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall             hold the fetch PC
//   x_valid, x_is_branch, x_is_jump, x_pc, x_taken, x_target,
//   x_pred_taken, x_pred_target
//                     resolved control-flow info from X plus the prediction it was fetched with
//   pc_f              current fetch PC (registered)
//   pred_taken_f      BTB prediction for pc_f
//   next_pc           value pc_f takes at the next edge
//   flush             mispredict this cycle; squash F and D
//   br_count          resolved branch+jump count (wraps)
//   mispred_count     mispredict count (wraps)
module fetch_pc_predictor
    import fetch_pred_pkg::*;
#(
    parameter int              XLEN        = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEF_RESET_PC),
    parameter int              BTB_ENTRIES = DEF_BTB_ENTRIES,
    parameter int              CNT_BITS    = DEF_CNT_BITS,
    localparam int             IDX_W       = idx_bits(BTB_ENTRIES),
    localparam int             TAG_W       = tag_bits(XLEN, BTB_ENTRIES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            x_valid,
    input  logic            x_is_branch,
    input  logic            x_is_jump,
    input  logic [XLEN-1:0] x_pc,
    input  logic            x_taken,
    input  logic [XLEN-1:0] x_target,
    input  logic            x_pred_taken,
    input  logic [XLEN-1:0] x_pred_target,
    output logic [XLEN-1:0] pc_f,
    output logic            pred_taken_f,
    output logic [XLEN-1:0] next_pc,
    output logic            flush,
    output logic [31:0]     br_count,
    output logic [31:0]     mispred_count
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic             lk_hit;
    logic             lk_taken;
    logic [XLEN-1:0]  pred_tgt;
    logic             resolve;
    logic             mispredict;
    logic             upd_en;
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;

    assign lk_idx = pc_f[IDX_W+1:2];
    assign lk_tag = pc_f[XLEN-1:IDX_W+2];
    assign up_idx = x_pc[IDX_W+1:2];
    assign up_tag = x_pc[XLEN-1:IDX_W+2];

    branch_target_buffer #(
        .XLEN     (XLEN),
        .ENTRIES  (BTB_ENTRIES),
        .CNT_BITS (CNT_BITS)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .lk_idx    (lk_idx),
        .lk_tag    (lk_tag),
        .lk_hit    (lk_hit),
        .lk_taken  (lk_taken),
        .lk_target (pred_tgt),
        .up_en     (upd_en),
        .up_idx    (up_idx),
        .up_tag    (up_tag),
        .up_taken  (x_taken),
        .up_jump   (x_is_jump),
        .up_target (x_target)
    );

    // A wrong direction always redirects; a wrong target only matters when
    // the instruction was actually taken.
    always_comb begin
        resolve    = x_valid && (x_is_branch || x_is_jump);
        mispredict = resolve &&
                     ((x_taken != x_pred_taken) ||
                      (x_taken && (x_pred_target != x_target)));
    end

    // Reset masks every side effect of an in-flight resolve.
    assign upd_en       = resolve && !rst;
    assign flush        = mispredict && !rst;
    assign pred_taken_f = lk_taken && !rst;

    // Redirect outranks stall so a mispredict is never lost while fetch waits.
    always_comb begin
        next_pc = pc_f + PC_STEP;
        if (rst) begin
            next_pc = RESET_PC;
        end else if (mispredict) begin
            next_pc = x_taken ? x_target : (x_pc + PC_STEP);
        end else if (stall) begin
            next_pc = pc_f;
        end else if (pred_taken_f) begin
            next_pc = pred_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f          <= RESET_PC;
            br_count      <= 32'd0;
            mispred_count <= 32'd0;
        end else begin
            pc_f <= next_pc;
            if (resolve) begin
                br_count <= br_count + 32'd1;
            end
            if (mispredict) begin
                mispred_count <= mispred_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_predictor.sv
module tb_fetch_pc_predictor;

    localparam logic [31:0] RST_PC = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        x_valid;
    logic        x_is_branch;
    logic        x_is_jump;
    logic [31:0] x_pc;
    logic        x_taken;
    logic [31:0] x_target;
    logic        x_pred_taken;
    logic [31:0] x_pred_target;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic [31:0] next_pc;
    logic        flush;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    always #5 clk = ~clk;

    fetch_pc_predictor #(
        .XLEN        (32),
        .RESET_PC    (RST_PC),
        .BTB_ENTRIES (16),
        .CNT_BITS    (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .x_valid       (x_valid),
        .x_is_branch   (x_is_branch),
        .x_is_jump     (x_is_jump),
        .x_pc          (x_pc),
        .x_taken       (x_taken),
        .x_target      (x_target),
        .x_pred_taken  (x_pred_taken),
        .x_pred_target (x_pred_target),
        .pc_f          (pc_f),
        .pred_taken_f  (pred_taken_f),
        .next_pc       (next_pc),
        .flush         (flush),
        .br_count      (br_count),
        .mispred_count (mispred_count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: 16-entry table addressed by (pc/4) mod 16, tag = pc/64,
    // counters as integers clamped to 0..3, predict taken when counter >= 2.
    logic [31:0] m_pc;
    logic [31:0] m_br;
    logic [31:0] m_mis;
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_cnt   [16];

    logic        e_pred;
    logic        e_flush;
    logic        e_res;
    logic [31:0] e_next;

    task automatic model_eval;
        int  i;
        bit  hit;
        bit  mis;
        i     = int'((m_pc / 4) % 16);
        hit   = m_valid[i] && (m_tag[i] == m_pc / 64);
        e_res = x_valid && (x_is_branch || x_is_jump);
        mis   = e_res && ((x_taken != x_pred_taken) || (x_taken && x_pred_target != x_target));
        e_flush = !rst && mis;
        e_pred  = !rst && hit && (m_cnt[i] >= 2);
        if (rst)          e_next = RST_PC;
        else if (mis)     e_next = x_taken ? x_target : x_pc + 32'd4;
        else if (stall)   e_next = m_pc;
        else if (e_pred)  e_next = m_tgt[i];
        else              e_next = m_pc + 32'd4;
    endtask

    task automatic model_clock;
        int j;
        bit hit;
        model_eval();
        if (rst) begin
            m_pc  = RST_PC;
            m_br  = 0;
            m_mis = 0;
            for (int k = 0; k < 16; k++) begin
                m_valid[k] = 1'b0;
                m_cnt[k]   = 1;
            end
        end else begin
            m_pc = e_next;
            if (e_res) begin
                m_br = m_br + 1;
                if (e_flush) m_mis = m_mis + 1;
                j   = int'((x_pc / 4) % 16);
                hit = m_valid[j] && (m_tag[j] == x_pc / 64);
                if (hit) begin
                    if (x_is_jump)    m_cnt[j] = 3;
                    else if (x_taken) m_cnt[j] = (m_cnt[j] == 3) ? 3 : m_cnt[j] + 1;
                    else              m_cnt[j] = (m_cnt[j] == 0) ? 0 : m_cnt[j] - 1;
                    if (x_taken) m_tgt[j] = x_target;
                end else if (x_taken) begin
                    m_valid[j] = 1'b1;
                    m_tag[j]   = x_pc / 64;
                    m_tgt[j]   = x_target;
                    m_cnt[j]   = x_is_jump ? 3 : 2;
                end
            end
        end
    endtask

    task automatic tick;
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
        model_eval();
    endtask

    task automatic clear_inputs;
        stall         = 1'b0;
        x_valid       = 1'b0;
        x_is_branch   = 1'b0;
        x_is_jump     = 1'b0;
        x_pc          = 32'd0;
        x_taken       = 1'b0;
        x_target      = 32'd0;
        x_pred_taken  = 1'b0;
        x_pred_target = 32'd0;
    endtask

    task automatic drive_resolve(input logic [31:0] pc, input bit jump, input bit taken,
                                 input logic [31:0] tgt, input bit ptaken,
                                 input logic [31:0] ptgt);
        x_valid       = 1'b1;
        x_is_branch   = !jump;
        x_is_jump     = jump;
        x_pc          = pc;
        x_taken       = taken;
        x_target      = tgt;
        x_pred_taken  = ptaken;
        x_pred_target = ptgt;
    endtask

    // Steer fetch to pc via a not-taken mispredict at pc-4 (a miss there leaves the BTB alone).
    task automatic redirect(input logic [31:0] pc);
        drive_resolve(pc - 32'd4, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0);
        tick();
        clear_inputs();
        settle();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_inputs();
        // An in-flight mispredicting resolve during reset must be ignored.
        drive_resolve(32'h4000_0010, 1'b0, 1'b1, 32'h4000_0100, 1'b0, 32'd0);
        tick();
        tick();
        settle();
        total++; if (pc_f !== RST_PC) begin bad++; $display("FAIL reset_pc_f got=%h want=%h", pc_f, RST_PC); end
        total++; if (next_pc !== RST_PC) begin bad++; $display("FAIL reset_next_pc got=%h want=%h", next_pc, RST_PC); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b want=0", flush); end
        total++; if (pred_taken_f !== 1'b0) begin bad++; $display("FAIL reset_pred got=%b want=0", pred_taken_f); end
        rst = 1'b0;
        clear_inputs();
        tick();
        total++; if (pc_f !== 32'h4000_0004) begin bad++; $display("FAIL release_pc1 got=%h want=%h", pc_f, 32'h4000_0004); end
        total++; if (br_count !== 32'd0) begin bad++; $display("FAIL reset_br_count got=%0d want=0", br_count); end
        tick();
        total++; if (pc_f !== 32'h4000_0008) begin bad++; $display("FAIL release_pc2 got=%h want=%h", pc_f, 32'h4000_0008); end
    endtask

    task automatic test_cold_taken;
        drive_resolve(32'h4000_0010, 1'b0, 1'b1, 32'h4000_0100, 1'b0, 32'd0);
        settle();
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL cold_flush got=%b want=1", flush); end
        total++; if (next_pc !== 32'h4000_0100) begin bad++; $display("FAIL cold_next got=%h want=%h", next_pc, 32'h4000_0100); end
        tick();
        clear_inputs();
        settle();
        total++; if (mispred_count !== 32'd1) begin bad++; $display("FAIL cold_mispred got=%0d want=1", mispred_count); end
        total++; if (pc_f !== 32'h4000_0100) begin bad++; $display("FAIL cold_pc got=%h want=%h", pc_f, 32'h4000_0100); end
        redirect(32'h4000_0010);
        total++; if (pred_taken_f !== 1'b1) begin bad++; $display("FAIL cold_hit_pred got=%b want=1", pred_taken_f); end
        total++; if (next_pc !== 32'h4000_0100) begin bad++; $display("FAIL cold_hit_next got=%h want=%h", next_pc, 32'h4000_0100); end
    endtask

    task automatic test_training;
        drive_resolve(32'h4000_0010, 1'b0, 1'b0, 32'd0, 1'b1, 32'h4000_0100);
        settle();
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL train_flush got=%b want=1", flush); end
        total++; if (next_pc !== 32'h4000_0014) begin bad++; $display("FAIL train_next got=%h want=%h", next_pc, 32'h4000_0014); end
        tick();
        clear_inputs();
        redirect(32'h4000_0010);
        total++; if (pred_taken_f !== 1'b0) begin bad++; $display("FAIL train_pred got=%b want=0", pred_taken_f); end
        total++; if (next_pc !== 32'h4000_0014) begin bad++; $display("FAIL train_fetch_next got=%h want=%h", next_pc, 32'h4000_0014); end
    endtask

    task automatic test_target_mismatch;
        drive_resolve(32'h4000_0010, 1'b0, 1'b1, 32'h4000_0100, 1'b0, 32'd0);
        tick();
        drive_resolve(32'h4000_0010, 1'b0, 1'b1, 32'h4000_0200, 1'b1, 32'h4000_0100);
        settle();
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL tgt_flush got=%b want=1", flush); end
        total++; if (next_pc !== 32'h4000_0200) begin bad++; $display("FAIL tgt_next got=%h want=%h", next_pc, 32'h4000_0200); end
        tick();
        clear_inputs();
        redirect(32'h4000_0010);
        total++; if (pred_taken_f !== 1'b1) begin bad++; $display("FAIL tgt_pred got=%b want=1", pred_taken_f); end
        total++; if (next_pc !== 32'h4000_0200) begin bad++; $display("FAIL tgt_btb_target got=%h want=%h", next_pc, 32'h4000_0200); end
    endtask

    task automatic test_stall;
        logic [31:0] held;
        stall = 1'b1;
        settle();
        held = pc_f;
        for (int k = 0; k < 3; k++) begin
            total++; if (next_pc !== held) begin bad++; $display("FAIL stall_next[%0d] got=%h want=%h", k, next_pc, held); end
            tick();
            total++; if (pc_f !== held) begin bad++; $display("FAIL stall_pc[%0d] got=%h want=%h", k, pc_f, held); end
        end
        drive_resolve(32'h4000_0040, 1'b0, 1'b1, 32'h4000_0500, 1'b0, 32'd0);
        settle();
        total++; if (next_pc !== 32'h4000_0500) begin bad++; $display("FAIL stall_redirect_next got=%h want=%h", next_pc, 32'h4000_0500); end
        tick();
        total++; if (pc_f !== 32'h4000_0500) begin bad++; $display("FAIL stall_redirect_pc got=%h want=%h", pc_f, 32'h4000_0500); end
        clear_inputs();
        redirect(32'h4000_0050);
        total++; if (pred_taken_f !== 1'b0) begin bad++; $display("FAIL alias_pred got=%b want=0", pred_taken_f); end
        total++; if (next_pc !== 32'h4000_0054) begin bad++; $display("FAIL alias_next got=%h want=%h", next_pc, 32'h4000_0054); end
    endtask

    task automatic test_wrap;
        redirect(32'hFFFF_FFFC);
        total++; if (next_pc !== 32'h0000_0000) begin bad++; $display("FAIL wrap_next got=%h want=0", next_pc); end
        tick();
        total++; if (pc_f !== 32'h0000_0000) begin bad++; $display("FAIL wrap_pc got=%h want=0", pc_f); end
        drive_resolve(32'hFFFF_FFFC, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0);
        settle();
        total++; if (next_pc !== 32'h0000_0000) begin bad++; $display("FAIL wrap_xpc_next got=%h want=0", next_pc); end
        tick();
        clear_inputs();
    endtask

    task automatic test_saturation;
        drive_resolve(32'h4000_0020, 1'b0, 1'b1, 32'h4000_0600, 1'b0, 32'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive_resolve(32'h4000_0020, 1'b0, 1'b1, 32'h4000_0600, 1'b1, 32'h4000_0600);
            settle();
            total++; if (flush !== 1'b0) begin bad++; $display("FAIL sat_flush[%0d] got=%b want=0", k, flush); end
            tick();
        end
        // Saturated at 3: one not-taken leaves it at 2, still predicting taken.
        drive_resolve(32'h4000_0020, 1'b0, 1'b0, 32'd0, 1'b1, 32'h4000_0600);
        tick();
        clear_inputs();
        redirect(32'h4000_0020);
        total++; if (pred_taken_f !== 1'b1) begin bad++; $display("FAIL sat_pred got=%b want=1", pred_taken_f); end
        total++; if (next_pc !== 32'h4000_0600) begin bad++; $display("FAIL sat_next got=%h want=%h", next_pc, 32'h4000_0600); end
        drive_resolve(32'h4000_0020, 1'b0, 1'b0, 32'd0, 1'b1, 32'h4000_0600);
        tick();
        clear_inputs();
        redirect(32'h4000_0020);
        total++; if (pred_taken_f !== 1'b0) begin bad++; $display("FAIL sat_down_pred got=%b want=0", pred_taken_f); end
    endtask

    task automatic test_jump;
        drive_resolve(32'h4000_0080, 1'b1, 1'b1, 32'h4000_0300, 1'b0, 32'd0);
        tick();
        // A jump allocates strongly taken, so one not-taken resolve still predicts taken.
        drive_resolve(32'h4000_0080, 1'b0, 1'b0, 32'd0, 1'b1, 32'h4000_0300);
        tick();
        clear_inputs();
        redirect(32'h4000_0080);
        total++; if (pred_taken_f !== 1'b1) begin bad++; $display("FAIL jump_pred got=%b want=1", pred_taken_f); end
        total++; if (next_pc !== 32'h4000_0300) begin bad++; $display("FAIL jump_next got=%h want=%h", next_pc, 32'h4000_0300); end
        total++; if (br_count !== m_br) begin bad++; $display("FAIL jump_br_count got=%0d want=%0d", br_count, m_br); end
        total++; if (mispred_count !== m_mis) begin bad++; $display("FAIL jump_mispred got=%0d want=%0d", mispred_count, m_mis); end
    endtask

    task automatic test_random;
        int kind;
        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(0, 63) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            kind        = $urandom_range(0, 2);
            x_valid     = $urandom_range(0, 1);
            x_is_branch = (kind == 1);
            x_is_jump   = (kind == 2);
            x_pc        = 32'h4000_0000 + 32'($urandom_range(0, 31)) * 4 +
                          (($urandom_range(0, 3) == 0) ? 32'h40 : 32'h0);
            x_taken     = x_is_jump ? 1'b1 : 1'($urandom_range(0, 1));
            x_target    = 32'h4000_0000 + 32'($urandom_range(0, 63)) * 4;
            x_pred_taken  = $urandom_range(0, 1);
            x_pred_target = ($urandom_range(0, 1) == 1) ? x_target :
                            32'h4000_0000 + 32'($urandom_range(0, 63)) * 4;
            settle();
            total++;
            if ({pc_f, pred_taken_f, next_pc, flush} !== {m_pc, e_pred, e_next, e_flush}) begin
                bad++;
                $display("FAIL rand_outputs[%0d] got pc=%h pred=%b next=%h flush=%b want pc=%h pred=%b next=%h flush=%b",
                         n, pc_f, pred_taken_f, next_pc, flush, m_pc, e_pred, e_next, e_flush);
            end
            total++;
            if ({br_count, mispred_count} !== {m_br, m_mis}) begin
                bad++;
                $display("FAIL rand_counts[%0d] got br=%0d mis=%0d want br=%0d mis=%0d",
                         n, br_count, mispred_count, m_br, m_mis);
            end
            tick();
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_cold_taken();
        test_training();
        test_target_mismatch();
        test_stall();
        test_wrap();
        test_saturation();
        test_jump();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
